// File: rtl/multdiv_ctrl.sv
// Sequencing controller for an iterative multiply/divide datapath: IDLE -> LOAD -> RUN -> DONE.
// Optional macro DIV_ZERO_EARLY_EN: a divide by zero skips RUN and reports from LOAD straight to DONE.
module multdiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_MULT,
  input  logic       ctrl_DIV,
  input  logic       div_zero,
  output logic       busy,
  output logic       load,
  output logic       step,
  output logic       op_div,
  output logic [5:0] cnt,
  output logic       data_resultRDY,
  output logic       data_exception
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             op_div_q, op_div_d;
  logic             dz_q, dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             load_q, load_d;
  logic             step_q, step_d;
  logic             rdy_q, rdy_d;
  logic             exc_q, exc_d;
  logic             last_iter;

  // Next state and next outputs; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    op_div_d  = op_div_q;
    dz_d      = dz_q;
    cnt_d     = '0;
    last_iter = (cnt_q == (op_div_q ? DIV_LAST : MULT_LAST));
    case (state_q)
      IDLE, DONE: begin
        if (ctrl_MULT || ctrl_DIV) begin
          state_d  = LOAD;
          op_div_d = ~ctrl_MULT;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        dz_d    = div_zero;
        state_d = RUN;
`ifdef DIV_ZERO_EARLY_EN
        if (op_div_q && div_zero) begin
          state_d = DONE;
        end
`endif
      end
      RUN: begin
        if (last_iter) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == RUN);
    load_d = (state_d == LOAD);
    step_d = (state_d == RUN);
    rdy_d  = (state_d == DONE);
    exc_d  = (state_d == DONE) && op_div_d && dz_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_div_q <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
      step_q   <= 1'b0;
      rdy_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      load_q   <= load_d;
      step_q   <= step_d;
      rdy_q    <= rdy_d;
      exc_q    <= exc_d;
    end
  end

  assign busy           = busy_q;
  assign load           = load_q;
  assign step           = step_q;
  assign op_div         = op_div_q;
  assign cnt            = cnt_q;
  assign data_resultRDY = rdy_q;
  assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomized and directed bench for multdiv_ctrl against an offset-from-start reference model.
module tb_multdiv_ctrl;

  localparam int MC = 32;
  localparam int DC = 33;

  logic       clk = 1'b0;
  logic       reset, ctrl_MULT, ctrl_DIV, div_zero;
  logic       busy, load, step, op_div, data_resultRDY, data_exception;
  logic [5:0] cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an operation is described by its cycle offset k from the accepting edge.
  bit m_active = 0;
  int m_k = 0;
  bit m_op = 0;
  bit m_dz = 0;
  int m_tgt = MC;

  always #5 clk = ~clk;

  multdiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .div_zero(div_zero), .busy(busy), .load(load), .step(step), .op_div(op_div),
    .cnt(cnt), .data_resultRDY(data_resultRDY), .data_exception(data_exception)
  );

  function automatic int done_k();
`ifdef DIV_ZERO_EARLY_EN
    if (m_op && m_dz) return 2;
`endif
    return m_tgt + 2;
  endfunction

  task automatic model_edge(input bit r, input bit m, input bit d, input bit z);
    bit acc;
    if (r) begin
      m_active = 0; m_k = 0; m_op = 0; m_dz = 0;
    end else begin
      if (m_active && m_k == 1) m_dz = z;
      acc = (!m_active || m_k == done_k()) && (m || d);
      if (acc) begin
        m_active = 1; m_k = 1; m_op = !m; m_tgt = m_op ? DC : MC;
      end else if (m_active) begin
        if (m_k == done_k()) m_active = 0;
        else m_k++;
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t k=%0d)", name, act, exp, $time, m_k);
    end
  endtask

  // One clock: drive, advance model at the edge, then check every output against the model.
  task automatic cyc(input bit r, input bit m, input bit d, input bit z);
    bit e_load, e_busy, e_step, e_rdy, e_exc;
    int e_cnt;
    reset = r; ctrl_MULT = m; ctrl_DIV = d; div_zero = z;
    @(posedge clk);
    model_edge(r, m, d, z);
    #1;
    e_load = m_active && m_k == 1;
    e_busy = m_active && m_k < done_k();
    e_step = m_active && m_k >= 2 && m_k < done_k();
    e_cnt  = e_step ? m_k - 2 : 0;
    e_rdy  = m_active && m_k == done_k();
    e_exc  = e_rdy && m_op && m_dz;
    vectors++;
    cmp("busy", int'(busy), int'(e_busy));
    cmp("load", int'(load), int'(e_load));
    cmp("step", int'(step), int'(e_step));
    cmp("cnt", int'(cnt), e_cnt);
    cmp("op_div", int'(op_div), int'(m_op));
    cmp("resultRDY", int'(data_resultRDY), int'(e_rdy));
    cmp("exception", int'(data_exception), int'(e_exc));
  endtask

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    cmp(name, act, exp);
  endtask

  // Start one operation and run until resultRDY (bounded); reports latency and observed behaviour.
  task automatic run_op(input bit m, input bit d, input bit z, input bit spam,
                        output int lat, output int steps, output int exc, output int opd,
                        output int maxcnt);
    lat = 0; steps = 0; exc = 0; maxcnt = 0;
    cyc(0, m, d, z);
    lit("load_at_1", int'(load), 1);
    opd = int'(op_div);
    for (int i = 2; i <= 100; i++) begin
      cyc(0, spam && i < 20, spam && i < 20, z);
      if (step) begin
        steps++;
        if (int'(cnt) > maxcnt) maxcnt = int'(cnt);
      end
      if (data_resultRDY) begin
        lat = i; exc = int'(data_exception);
        break;
      end
    end
  endtask

  initial begin
    int lat, steps, exc, opd, maxcnt, rdy_cnt, guard;
    reset = 1; ctrl_MULT = 0; ctrl_DIV = 0; div_zero = 0;
    cyc(1, 1, 1, 1);
    cyc(1, 0, 0, 0);
    lit("reset_busy", int'(busy), 0);
    lit("reset_outs", int'({load, step, op_div, data_resultRDY, data_exception}), 0);
    lit("reset_cnt", int'(cnt), 0);

    run_op(1, 0, 0, 0, lat, steps, exc, opd, maxcnt);
    lit("mult_latency", lat, 34);
    lit("mult_steps", steps, 32);
    lit("mult_maxcnt", maxcnt, 31);
    lit("mult_exc", exc, 0);
    lit("mult_opdiv", opd, 0);
    cyc(0, 0, 0, 0);

    run_op(0, 1, 0, 0, lat, steps, exc, opd, maxcnt);
    lit("div_latency", lat, 35);
    lit("div_steps", steps, 33);
    lit("div_opdiv", opd, 1);
    lit("div_exc", exc, 0);
    cyc(0, 0, 0, 0);

    run_op(0, 1, 1, 0, lat, steps, exc, opd, maxcnt);
`ifdef DIV_ZERO_EARLY_EN
    lit("dz_latency", lat, 2);
    lit("dz_steps", steps, 0);
`else
    lit("dz_latency", lat, 35);
    lit("dz_steps", steps, 33);
`endif
    lit("dz_exc", exc, 1);
    cyc(0, 0, 0, 0);

    run_op(1, 1, 1, 1, lat, steps, exc, opd, maxcnt);
    lit("both_opdiv", opd, 0);
    lit("both_latency", lat, 34);
    lit("both_steps", steps, 32);
    lit("both_exc", exc, 0);

    // Start coincident with the previous resultRDY must restart with no gap.
    run_op(0, 1, 0, 0, lat, steps, exc, opd, maxcnt);
    lit("b2b_latency", lat, 35);
    run_op(1, 0, 0, 0, lat, steps, exc, opd, maxcnt);
    lit("b2b2_latency", lat, 34);
    cyc(0, 0, 0, 0);

    // Reset in the middle of a multiply aborts it.
    cyc(0, 1, 0, 0);
    guard = 0;
    while (cnt != 6'd10 && guard < 60) begin
      cyc(0, 0, 0, 0);
      guard++;
    end
    lit("reach_cnt10", int'(cnt), 10);
    cyc(1, 0, 0, 0);
    lit("abort_outs", int'({busy, load, step, op_div, cnt, data_resultRDY, data_exception}), 0);
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0);
      if (data_resultRDY) rdy_cnt++;
    end
    lit("abort_no_rdy", rdy_cnt, 0);

    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 32, RUN-phase length in cycles for multiply; legal range 1..63.
REQ-002 Parameter DIV_CYCLES, default 33, RUN-phase length in cycles for divide; legal range 1..63.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ctrl_MULT  input  1  multiply start request, sampled every cycle.
REQ-006 ctrl_DIV  input  1  divide start request, sampled every cycle.
REQ-007 div_zero  input  1  datapath flag, divisor operand == 0; valid while load is high.
REQ-008 busy  output  1  operation in progress (LOAD or RUN); pipeline stall source.
REQ-009 load  output  1  datapath operand-load strobe.
REQ-010 step  output  1  datapath iteration enable.
REQ-011 op_div  output  1  latched operation: 1 = divide, 0 = multiply.
REQ-012 cnt  output  6  current iteration index within RUN.
REQ-013 data_resultRDY  output  1  one-cycle result-valid pulse.
REQ-014 data_exception  output  1  divide-by-zero flag, valid only with data_resultRDY.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN, DONE; exactly one active per cycle.
REQ-016 IDLE or DONE: ctrl_MULT or ctrl_DIV high -> LOAD; else -> IDLE.
REQ-017 Both starts high in same cycle: multiply wins; op_div latched 0.
REQ-018 op_div latched on the accepting edge; held constant through LOAD, RUN, DONE.
REQ-019 Starts in LOAD or RUN SHALL be ignored (not queued, no state effect).
REQ-020 LOAD: load=1, busy=1, step=0, cnt=0; div_zero latched into internal flag; next -> RUN.
REQ-021 RUN: step=1, busy=1; cnt increments by 1 per cycle, starting at 0.
REQ-022 RUN -> DONE when cnt == target-1 (target = DIV_CYCLES if op_div else MULT_CYCLES); RUN lasts exactly target cycles.
REQ-023 cnt SHALL never wrap; it holds 0 outside RUN.
REQ-024 DONE: data_resultRDY=1, busy=0, step=0, load=0, for exactly one cycle.
REQ-025 data_exception = op_div & latched div_zero in DONE; 0 in all other states.
REQ-026 Latency: start sampled at edge E -> data_resultRDY high in cycle E+target+2.
REQ-027 Back-to-back: start accepted in DONE -> LOAD next cycle, no idle gap.

Reset
REQ-028 reset high at an edge SHALL force IDLE, op_div=0, cnt=0, latched div_zero=0, overriding any start.
REQ-029 After reset all outputs SHALL be 0.
REQ-030 Reset mid-operation SHALL abort it; no data_resultRDY pulse for the aborted op.

Configuration
REQ-031 Macro DIV_ZERO_EARLY_EN defined: LOAD with ctrl op divide and div_zero=1 -> DONE directly (skip RUN), data_exception=1, resultRDY 2 cycles after start.
REQ-032 Macro undefined: divide-by-zero runs full DIV_CYCLES RUN phase, then flags data_exception in DONE.

Verification
REQ-033 Reset, ctrl_MULT pulse, defaults -> load at +1, step high 32 cycles, cnt 0..31, resultRDY at +34, exception 0.
REQ-034 ctrl_DIV with div_zero=0 -> RUN 33 cycles, resultRDY at +35, op_div=1, exception 0.
REQ-035 ctrl_DIV with div_zero=1: macro off -> resultRDY at +35, exception 1; macro on -> resultRDY at +2, exception 1, step never high.
REQ-036 ctrl_MULT and ctrl_DIV same cycle -> op_div=0, 32 RUN cycles; extra starts during RUN -> no effect on cnt or latency.
REQ-037 Start pulse coincident with resultRDY -> load next cycle, second resultRDY exactly target+2 cycles later.
REQ-038 reset asserted at cnt=10 of a multiply -> IDLE next edge, all outputs 0, no resultRDY within 40 cycles.
